// File: rtl/fetch_ctrl_if.sv
// Fetch-stage sequencer bus: EX redirect, stall, debug requests and the fetch outputs.
// master = core/debug side, slave = fetch_ctrl.
interface fetch_ctrl_if #(
    parameter int unsigned PC_W = 12
);
    localparam int unsigned CNT_W = 32;

    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             halt_req;
    logic             step_req;
    logic             resume_req;
    logic [PC_W-1:0]  pc_fetch;
    logic             ir_en;
    logic             ex_valid;
    logic             halted;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output stall, redirect_valid, redirect_pc, halt_req, step_req, resume_req,
        input  pc_fetch, ir_en, ex_valid, halted, retired_count, flush_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt_req, step_req, resume_req,
        output pc_fetch, ir_en, ex_valid, halted, retired_count, flush_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC, EX valid/bubble tagging, redirect flush, debug halt/step/resume.
// Optional retire/flush counters enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int unsigned    PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic            ex_valid, ex_valid_n;
    logic            halted;
    logic            ir_en;
    logic            redir;

    // A redirect only counts when the EX instruction that raised it is real.
    assign redir = bus.redirect_valid & ex_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            ex_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ex_valid <= ex_valid_n;
            halted   <= (state_n != RUN);
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ex_valid_n = ex_valid;
        ir_en      = 1'b0;
        unique case (state)
            RUN: begin
                if (redir) begin
                    pc_n       = bus.redirect_pc;
                    ir_en      = 1'b1;
                    ex_valid_n = 1'b0;
                    if (bus.halt_req) state_n = HALT;
                end else if (bus.halt_req) begin
                    ex_valid_n = 1'b0;
                    state_n    = HALT;
                end else if (!bus.stall) begin
                    ir_en      = 1'b1;
                    pc_n       = pc + PC_W'(1);
                    ex_valid_n = 1'b1;
                end
            end
            HALT: begin
                ex_valid_n = 1'b0;
                if (redir) pc_n = bus.redirect_pc;
                if (bus.resume_req) begin
                    state_n = RUN;
                end else if (bus.step_req && !redir && !bus.stall) begin
                    state_n = STEP;
                end
            end
            STEP: begin
                ir_en      = 1'b1;
                pc_n       = pc + PC_W'(1);
                ex_valid_n = 1'b1;
                state_n    = HALT;
            end
            default: begin
                state_n    = RUN;
                ex_valid_n = 1'b0;
            end
        endcase
    end

    assign bus.pc_fetch = pc;
    assign bus.ir_en    = ir_en;
    assign bus.ex_valid = ex_valid;
    assign bus.halted   = halted;

`ifdef FETCH_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, flush_q;

    // Retire when the EX instruction leaves: not stalled, or killed-and-redirected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            flush_q   <= '0;
        end else begin
            if (ex_valid && (!bus.stall || redir)) retired_q <= retired_q + CNT_W'(1);
            if (redir)                             flush_q   <= flush_q + CNT_W'(1);
        end
    end

    assign bus.retired_count = retired_q;
    assign bus.flush_count   = flush_q;
`else
    assign bus.retired_count = CNT_W'(0);
    assign bus.flush_count   = CNT_W'(0);
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scoreboarded per-cycle expectations for each scenario.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.PC_W(12)) bus ();
    fetch_ctrl_if #(.PC_W(4))  bus2 ();

    fetch_ctrl #(.PC_W(12), .RESET_PC(12'd0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    fetch_ctrl #(.PC_W(4),  .RESET_PC(4'd14)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct packed {
        logic st, rv; logic [11:0] rpc; logic hr, sr, rr;
        logic ir; logic [11:0] pc; logic ex, ha;
    } row_t;
    typedef struct packed { logic ir; logic [11:0] pc; logic ex, ha; } exp_t;

    row_t        stim[$];
    exp_t        sb[$];
    logic [3:0]  wsb[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_ex  = 1'b0;
    logic [31:0] m_ret = '0;
    logic [31:0] m_fl  = '0;

    task automatic add(input logic st, rv, input logic [11:0] rpc, input logic hr, sr, rr,
                       input logic ir, input logic [11:0] pc, input logic ex, ha);
        row_t r;
        r = '{st: st, rv: rv, rpc: rpc, hr: hr, sr: sr, rr: rr, ir: ir, pc: pc, ex: ex, ha: ha};
        stim.push_back(r);
    endtask

    // Drive one row, capture ir_en mid-cycle, queue the post-edge expectation, advance one edge.
    task automatic apply(output logic ir_obs);
        row_t r;
        logic redir_m;
        r = stim.pop_front();
        bus.stall = r.st; bus.redirect_valid = r.rv; bus.redirect_pc = r.rpc;
        bus.halt_req = r.hr; bus.step_req = r.sr; bus.resume_req = r.rr;
        #1 ir_obs = bus.ir_en;
        redir_m = r.rv & m_ex;
        if (m_ex && (!r.st || redir_m)) m_ret = m_ret + 32'd1;
        if (redir_m) m_fl = m_fl + 32'd1;
        m_ex = r.ex;
        sb.push_back('{ir: r.ir, pc: r.pc, ex: r.ex, ha: r.ha});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.pc_fetch, bus.ex_valid, bus.halted} !== {12'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_state got pc=%0h ex=%b ha=%b exp pc=0 ex=0 ha=0",
                            bus.pc_fetch, bus.ex_valid, bus.halted);
        end
        total++;
        if ({bus.retired_count, bus.flush_count} !== 64'd0) begin
            bad++; $display("FAIL reset_counters got ret=%0d fl=%0d exp 0 0",
                            bus.retired_count, bus.flush_count);
        end
        total++;
        if (bus2.pc_fetch !== 4'd14) begin
            bad++; $display("FAIL reset_pc_w4 got pc=%0d exp 14", bus2.pc_fetch);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] e;
        wsb.push_back(4'd15); wsb.push_back(4'd0); wsb.push_back(4'd1);
        @(negedge clk);
        bus2.stall = 1'b0;
        while (wsb.size() != 0) begin
            @(posedge clk); #1;
            e = wsb.pop_front();
            total++;
            if (bus2.pc_fetch !== e) begin
                bad++; $display("FAIL pc_wrap got pc=%0d exp %0d", bus2.pc_fetch, e);
            end
        end
        bus2.stall = 1'b1;
    endtask

    task automatic test_free_run();
        logic ir; exp_t e;
        for (int k = 1; k <= 4; k++) add(0,0,0,0,0,0, 1,12'(k),1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL free_run got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
    endtask

    task automatic test_redirect();
        logic ir; exp_t e; logic [31:0] ef;
        add(0,0,0,0,0,0,      1,12'h005,1,0);
        add(0,1,12'h040,0,0,0, 1,12'h040,0,0);
        add(0,0,0,0,0,0,      1,12'h041,1,0);
        add(1,1,12'h050,0,0,0, 1,12'h050,0,0);
        add(0,0,0,0,0,0,      1,12'h051,1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL redirect got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
`ifdef FETCH_CTRL_PERF_EN
        ef = m_fl;
`else
        ef = 32'd0;
`endif
        total++;
        if (bus.flush_count !== ef) begin
            bad++; $display("FAIL flush_count got %0d exp %0d", bus.flush_count, ef);
        end
    endtask

    task automatic test_ignored_redirect();
        logic ir; exp_t e;
        add(0,1,12'h080,0,0,0, 1,12'h080,0,0);
        add(0,1,12'h200,0,0,0, 1,12'h081,1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL ignored_redirect got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
    endtask

    task automatic test_stall();
        logic ir; exp_t e;
        add(0,1,12'd6,0,0,0, 1,12'd6,0,0);
        add(0,0,0,0,0,0,     1,12'd7,1,0);
        for (int k = 0; k < 3; k++) add(1,0,0,0,0,0, 0,12'd7,1,0);
        add(0,0,0,0,0,0,     1,12'd8,1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL stall got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
    endtask

    task automatic test_halt_step();
        logic ir; exp_t e;
        add(0,1,12'd9,0,0,0, 1,12'd9,0,0);
        add(0,0,0,0,0,0,     1,12'd10,1,0);
        add(0,0,0,1,0,0,     0,12'd10,0,1);
        add(0,0,0,0,0,0,     0,12'd10,0,1);
        add(0,0,0,0,1,0,     0,12'd10,0,1);
        add(0,0,0,0,0,0,     1,12'd11,1,1);
        add(0,0,0,0,0,0,     0,12'd11,0,1);
        add(0,0,0,0,1,0,     0,12'd11,0,1);
        add(0,0,0,0,0,0,     1,12'd12,1,1);
        add(1,0,0,0,1,0,     0,12'd12,0,1);
        add(0,0,0,0,0,0,     0,12'd12,0,1);
        add(0,0,0,0,1,1,     0,12'd12,0,0);
        add(0,0,0,0,0,0,     1,12'd13,1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL halt_step got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ir; exp_t e; logic [31:0] er, ef;
        add(0,1,12'h020,1,0,0, 1,12'h020,0,1);
        add(0,0,0,0,1,0,       0,12'h020,0,1);
        add(0,0,0,0,0,0,       1,12'h021,1,1);
        add(0,1,12'h030,0,1,0, 0,12'h030,0,1);
        add(0,0,0,0,0,0,       0,12'h030,0,1);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL back_to_back got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
`ifdef FETCH_CTRL_PERF_EN
        er = m_ret; ef = m_fl;
`else
        er = 32'd0; ef = 32'd0;
`endif
        total++;
        if ({bus.retired_count, bus.flush_count} !== {er, ef}) begin
            bad++; $display("FAIL perf_counters got ret=%0d fl=%0d exp ret=%0d fl=%0d",
                            bus.retired_count, bus.flush_count, er, ef);
        end
    endtask

    task automatic test_reset_mid_halt();
        logic ir; exp_t e;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.pc_fetch, bus.ex_valid, bus.halted, bus.retired_count, bus.flush_count}
            !== {12'd0, 1'b0, 1'b0, 64'd0}) begin
            bad++; $display("FAIL async_reset got pc=%0h ex=%b ha=%b ret=%0d fl=%0d exp 0 0 0 0 0",
                            bus.pc_fetch, bus.ex_valid, bus.halted, bus.retired_count, bus.flush_count);
        end
        m_ex = 1'b0; m_ret = '0; m_fl = '0;
        @(negedge clk);
        rst = 1'b0;
        add(0,0,0,0,0,0, 1,12'd1,1,0);
        add(0,0,0,0,0,0, 1,12'd2,1,0);
        while (stim.size() != 0) begin
            apply(ir); e = sb.pop_front(); total++;
            if ({ir, bus.pc_fetch, bus.ex_valid, bus.halted} !== e) begin
                bad++; $display("FAIL post_reset got ir/pc/ex/ha=%b/%0h/%b/%b exp %b/%0h/%b/%b",
                                ir, bus.pc_fetch, bus.ex_valid, bus.halted, e.ir, e.pc, e.ex, e.ha);
            end
        end
    endtask

    initial begin
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.halt_req = 1'b0; bus.step_req = 1'b0; bus.resume_req = 1'b0;
        bus2.stall = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
        bus2.halt_req = 1'b0; bus2.step_req = 1'b0; bus2.resume_req = 1'b0;
        test_reset();
        test_free_run();
        test_redirect();
        test_ignored_redirect();
        test_stall();
        test_halt_step();
        test_back_to_back();
        test_reset_mid_halt();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
